// File: rtl/cpu4_pkg.sv
// Shared opcode constants and sequencer state encoding for the 4-bit CPU execute path.
package cpu4_pkg;

    localparam logic [3:0] OPR_ADD = 4'b1000;
    localparam logic [3:0] OPR_ACC = 4'b1111;

    localparam logic [3:0] OPA_CLB = 4'd0;
    localparam logic [3:0] OPA_CLC = 4'd1;
    localparam logic [3:0] OPA_IAC = 4'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_READ,
        ST_EXEC,
        ST_HALT
    } cpu4_state_t;

endpackage

// File: rtl/cpu4_instr_decode.sv
// Combinational decode of opr/opa into one-hot operation strobes plus an illegal flag.
module cpu4_instr_decode
    import cpu4_pkg::*;
(
    input  logic [3:0] opr,
    input  logic [3:0] opa,
    output logic       dec_clb,
    output logic       dec_clc,
    output logic       dec_iac,
    output logic       dec_add,
    output logic       dec_illegal
);

    logic acc_grp;

    always_comb begin
        acc_grp     = (opr == OPR_ACC);
        dec_add     = (opr == OPR_ADD);
        dec_clb     = acc_grp && (opa == OPA_CLB);
        dec_clc     = acc_grp && (opa == OPA_CLC);
        dec_iac     = acc_grp && (opa == OPA_IAC);
        dec_illegal = !(dec_add || dec_clb || dec_clc || dec_iac);
    end

endmodule

// File: rtl/cpu4_exec_ctrl.sv
// Execute sequencer: accepts instructions, sequences register reads, owns acc and carry.
// Optional CPU4_ILLEGAL_TRAP_EN: unrecognized encodings set sticky illegal and halt until reset.
module cpu4_exec_ctrl
    import cpu4_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       instr_valid,
    input  logic [7:0] instr,
    output logic       instr_ready,
    output logic       reg_rd,
    output logic [3:0] reg_addr,
    input  logic [3:0] reg_data,
    output logic [3:0] acc,
    output logic       carry,
`ifdef CPU4_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       done
);

    cpu4_state_t state, state_nxt;

    logic [7:0] instr_q;
    logic [3:0] operand_q;
    logic [3:0] addr_q;
    logic [3:0] acc_q;
    logic       carry_q;

    logic dec_clb, dec_clc, dec_iac, dec_add, dec_illegal;
    logic [3:0] res_acc;
    logic       res_carry;

    cpu4_instr_decode u_decode (
        .opr         (instr_q[7:4]),
        .opa         (instr_q[3:0]),
        .dec_clb     (dec_clb),
        .dec_clc     (dec_clc),
        .dec_iac     (dec_iac),
        .dec_add     (dec_add),
        .dec_illegal (dec_illegal)
    );

    always_comb begin
        state_nxt = state;
        unique case (state)
            ST_IDLE:   if (instr_valid) state_nxt = ST_DECODE;
            ST_DECODE: begin
                if (dec_add) begin
                    state_nxt = ST_READ;
`ifdef CPU4_ILLEGAL_TRAP_EN
                end else if (dec_illegal) begin
                    state_nxt = ST_HALT;
`endif
                end else begin
                    state_nxt = ST_EXEC;
                end
            end
            ST_READ:   state_nxt = ST_EXEC;
            ST_EXEC:   state_nxt = ST_IDLE;
            ST_HALT:   state_nxt = ST_HALT;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // reg_addr presents opa combinationally with the strobe, then holds it while idle
    always_comb begin
        instr_ready = (state == ST_IDLE);
        done        = (state == ST_EXEC);
        reg_rd      = (state == ST_DECODE) && dec_add;
        reg_addr    = reg_rd ? instr_q[3:0] : addr_q;
        acc         = acc_q;
        carry       = carry_q;
    end

    always_comb begin
        res_acc   = acc_q;
        res_carry = carry_q;
        if (dec_add) begin
            {res_carry, res_acc} = {1'b0, acc_q} + {1'b0, operand_q} + {4'b0000, carry_q};
        end else if (dec_iac) begin
            {res_carry, res_acc} = {1'b0, acc_q} + 5'd1;
        end else if (dec_clc) begin
            res_carry = 1'b0;
        end else if (dec_clb) begin
            res_acc   = '0;
            res_carry = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            instr_q   <= '0;
            operand_q <= '0;
            addr_q    <= '0;
            acc_q     <= '0;
            carry_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == ST_IDLE && instr_valid) begin
                instr_q <= instr;
            end
            if (reg_rd) begin
                addr_q <= instr_q[3:0];
            end
            if (state == ST_READ) begin
                operand_q <= reg_data;
            end
            if (state == ST_EXEC && !dec_illegal) begin
                acc_q   <= res_acc;
                carry_q <= res_carry;
            end
        end
    end

`ifdef CPU4_ILLEGAL_TRAP_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal <= 1'b0;
        end else if (state == ST_DECODE && dec_illegal) begin
            illegal <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_cpu4_exec_ctrl.sv
// Directed self-checking bench for cpu4_exec_ctrl with a small register-file model.
module tb_cpu4_exec_ctrl;

    logic       clk;
    logic       rst_n;
    logic       instr_valid;
    logic [7:0] instr;
    logic       instr_ready;
    logic       reg_rd;
    logic [3:0] reg_addr;
    logic [3:0] reg_data;
    logic [3:0] acc;
    logic       carry;
    logic       done;
`ifdef CPU4_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int unsigned vectors;
    int unsigned miscompares;
    logic [3:0] regs [16];

    cpu4_exec_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .reg_rd      (reg_rd),
        .reg_addr    (reg_addr),
        .reg_data    (reg_data),
        .acc         (acc),
        .carry       (carry),
`ifdef CPU4_ILLEGAL_TRAP_EN
        .illegal     (illegal),
`endif
        .done        (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (reg_rd) reg_data <= regs[reg_addr];
    end

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one instruction and checks the handshake/strobe/done timeline cycle by cycle.
    task automatic run(input logic [7:0] i, input bit is_add);
        @(negedge clk);
        instr       = i;
        instr_valid = 1'b1;
        chk("ready_idle", {7'b0, instr_ready}, 8'h01);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        chk("ready_t1", {7'b0, instr_ready}, 8'h00);
        chk("done_t1", {7'b0, done}, 8'h00);
        chk("reg_rd_t1", {7'b0, reg_rd}, {7'b0, is_add});
        if (is_add) begin
            chk("reg_addr_t1", {4'b0, reg_addr}, {4'b0, i[3:0]});
            @(posedge clk); #1;
            chk("reg_rd_read", {7'b0, reg_rd}, 8'h00);
            chk("done_read", {7'b0, done}, 8'h00);
        end
        @(posedge clk); #1;
        chk("done_exec", {7'b0, done}, 8'h01);
        @(posedge clk); #1;
        chk("done_after", {7'b0, done}, 8'h00);
        chk("ready_after", {7'b0, instr_ready}, 8'h01);
    endtask

    task automatic chk_state(input string tag, input logic c, input logic [3:0] a);
        chk(tag, {3'b0, carry, acc}, {3'b0, c, a});
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        foreach (regs[k]) regs[k] = 4'h0;
        regs[2]  = 4'hE;
        regs[5]  = 4'hF;
        regs[9]  = 4'h8;
        reg_data = 4'h0;
        instr_valid = 1'b0;
        instr = 8'h00;
        rst_n = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        chk_state("reset_acc_carry", 1'b0, 4'h0);
        chk("reset_ready", {7'b0, instr_ready}, 8'h01);
        chk("reset_reg_rd", {7'b0, reg_rd}, 8'h00);
        chk("reset_reg_addr", {4'b0, reg_addr}, 8'h00);
        chk("reset_done", {7'b0, done}, 8'h00);
`ifdef CPU4_ILLEGAL_TRAP_EN
        chk("reset_illegal", {7'b0, illegal}, 8'h00);
`endif
        @(negedge clk);
        rst_n = 1'b1;

        // IAC x3
        for (int n = 0; n < 3; n++) run(8'hF2, 1'b0);
        chk_state("iac3", 1'b0, 4'h3);

        // ADD R2: 3 + E + 0 = 0x11
        run(8'h82, 1'b1);
        chk_state("add_r2", 1'b1, 4'h1);
        chk("reg_addr_hold", {4'b0, reg_addr}, 8'h02);

        // CLB, ADD R5 -> F/0, IAC -> 0/1, CLC -> 0/0
        run(8'hF0, 1'b0);
        chk_state("clb", 1'b0, 4'h0);
        run(8'h85, 1'b1);
        chk_state("add_r5", 1'b0, 4'hF);
        run(8'hF2, 1'b0);
        chk_state("iac_wrap", 1'b1, 4'h0);
        run(8'hF1, 1'b0);
        chk_state("clc", 1'b0, 4'h0);

        // acc=F (ADD R5), then ADD R9: F + 8 = 0x17
        run(8'h85, 1'b1);
        run(8'h89, 1'b1);
        chk_state("add_r9", 1'b1, 4'h7);

        // CLB with instr_valid held high across the whole instruction
        @(negedge clk);
        instr = 8'hF0;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        chk("hold_ready_dec", {7'b0, instr_ready}, 8'h00);
        @(posedge clk); #1;
        chk("hold_ready_exec", {7'b0, instr_ready}, 8'h00);
        chk("hold_done_exec", {7'b0, done}, 8'h01);
        @(posedge clk); #1;
        chk("hold_ready_idle", {7'b0, instr_ready}, 8'h01);
        chk_state("hold_clb", 1'b0, 4'h0);
        @(posedge clk); #1;
        chk("hold_reaccept", {7'b0, instr_ready}, 8'h00);
        instr_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("hold_ready_end", {7'b0, instr_ready}, 8'h01);

        // Reset during READ of an ADD, with nonzero acc beforehand
        run(8'hF2, 1'b0);
        chk_state("pre_abort", 1'b0, 4'h1);
        @(negedge clk);
        instr = 8'h82;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_state("abort_acc_carry", 1'b0, 4'h0);
        chk("abort_ready", {7'b0, instr_ready}, 8'h01);
        chk("abort_done", {7'b0, done}, 8'h00);
        repeat (2) @(posedge clk);
        #1;
        chk("abort_done_held", {7'b0, done}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_done_release", {7'b0, done}, 8'h00);

        // Unrecognized encoding 8'h35 with acc=2, carry=0
        run(8'hF2, 1'b0);
        run(8'hF2, 1'b0);
        chk_state("pre_illegal", 1'b0, 4'h2);
`ifdef CPU4_ILLEGAL_TRAP_EN
        @(negedge clk);
        instr = 8'h35;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(posedge clk); #1;
            chk("halt_ready", {7'b0, instr_ready}, 8'h00);
            chk("halt_done", {7'b0, done}, 8'h00);
            chk("halt_illegal", {7'b0, illegal}, 8'h01);
        end
        chk_state("halt_acc_carry", 1'b0, 4'h2);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("halt_reset_illegal", {7'b0, illegal}, 8'h00);
        chk("halt_reset_ready", {7'b0, instr_ready}, 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
`else
        run(8'h35, 1'b0);
        chk_state("nop_acc_carry", 1'b0, 4'h2);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
